// File: rtl/instr_fetch_unit_if.sv
// Fetch unit boundary: decode link, redirect, program-load port and instruction memory pins.
// master = fetch unit, slave = surrounding core/memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              halted;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_mode;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    input  start, redirect_valid, redirect_pc, inst_ready,
           load_valid, load_addr, load_data, imem_rdata,
    output inst_valid, inst_data, inst_pc, halted, load_ready,
           imem_addr, imem_mode, imem_wdata
  );

  modport slave (
    output start, redirect_valid, redirect_pc, inst_ready,
           load_valid, load_addr, load_data, imem_rdata,
    input  inst_valid, inst_data, inst_pc, halted, load_ready,
           imem_addr, imem_mode, imem_wdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC owner, 1-cycle imem read, 2-entry output buffer; start->valid in 2 cycles, 1/cycle steady.
// Backpressure: issue stalls when buffered + in-flight words would exceed 2; head held while valid & !ready.
module instr_fetch_unit #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 25
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              epoch;
  logic              inflight;
  logic              inflight_tag;
  logic [ADDR_W-1:0] inflight_pc;
  logic              e1_vld;
  logic [DATA_W-1:0] e1_data;
  logic [ADDR_W-1:0] e1_pc;

  logic       pop;
  logic       redirect;
  logic       issue;
  logic       push;
  logic       load_fire;
  logic       pc_in_range;
  logic [1:0] occ;
  logic [2:0] demand;

  assign pop         = bus.inst_valid & bus.inst_ready;
  assign occ         = {1'b0, bus.inst_valid} + {1'b0, e1_vld};
  // pop implies occ >= 1, so this never underflows
  assign demand      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign pc_in_range = ({1'b0, pc} < DEPTH_L);
  assign redirect    = bus.redirect_valid & (state != IDLE);
  assign issue       = (state == FETCH) & ~redirect & (demand < 3'd2) & pc_in_range;
  assign push        = inflight & (inflight_tag == epoch) & ~redirect;

  // rst gates load_ready so no write strobe can leak out while the state is being reset
  assign bus.load_ready = ~rst & ((state == IDLE) | (state == HALT));
  assign load_fire      = bus.load_valid & bus.load_ready;
  assign bus.imem_mode  = ~load_fire;
  assign bus.imem_addr  = load_fire ? bus.load_addr : (issue ? pc : '0);
  assign bus.imem_wdata = load_fire ? bus.load_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= '0;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_tag   <= 1'b0;
      inflight_pc    <= '0;
      e1_vld         <= 1'b0;
      e1_data        <= '0;
      e1_pc          <= '0;
      bus.inst_valid <= 1'b0;
      bus.inst_data  <= '0;
      bus.inst_pc    <= '0;
      bus.halted     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_tag <= epoch;
        inflight_pc  <= pc;
        pc           <= pc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= FETCH;
            pc    <= '0;
          end
        end
        FETCH: begin
          if (!redirect && !pc_in_range) begin
            state      <= HALT;
            bus.halted <= 1'b1;
          end
        end
        default: ;
      endcase

      if (redirect) begin
        state          <= FETCH;
        bus.halted     <= 1'b0;
        pc             <= bus.redirect_pc;
        epoch          <= ~epoch;
        bus.inst_valid <= 1'b0;
        e1_vld         <= 1'b0;
      end else if (pop || !bus.inst_valid) begin
        // head is free this cycle: refill from the second entry first to keep order
        if (e1_vld) begin
          bus.inst_valid <= 1'b1;
          bus.inst_data  <= e1_data;
          bus.inst_pc    <= e1_pc;
          e1_vld         <= push;
          if (push) begin
            e1_data <= bus.imem_rdata;
            e1_pc   <= inflight_pc;
          end
        end else begin
          bus.inst_valid <= push;
          if (push) begin
            bus.inst_data <= bus.imem_rdata;
            bus.inst_pc   <= inflight_pc;
          end
        end
      end else if (push) begin
        e1_vld  <= 1'b1;
        e1_data <= bus.imem_rdata;
        e1_pc   <= inflight_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered-address instruction memory model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .MEM_DEPTH(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] dat;
  } xfer_t;

  logic [31:0] mem     [0:31];
  logic [31:0] exp_mem [0:31];
  logic [4:0]  addr_q;
  xfer_t       got_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          wr_cycles = 0;
  int          bad_addr  = 0;
  int          wr_base;

  function automatic logic [31:0] img(input int i);
    case (i)
      0:       return 32'h0022_0020;
      1:       return 32'h0041_0022;
      20:      return 32'h0800_0002;
      24:      return 32'h2841_0064;
      default: return 32'hA000_0000 | i;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = img(i);
      exp_mem[i] = img(i);
    end
    addr_q = '0;
  end

  always @(posedge clk) begin
    if (!bus.imem_mode) mem[bus.imem_addr] <= bus.imem_wdata;
    addr_q <= bus.imem_addr;
  end
  assign bus.imem_rdata = mem[addr_q];

  // Inputs change only just after posedge, so negedge sees what the next edge will sample
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inst_valid && bus.inst_ready) got_q.push_back('{pc: bus.inst_pc, dat: bus.inst_data});
      if (!bus.imem_mode) wr_cycles++;
      if (bus.imem_mode && bus.imem_addr == 5'd25) bad_addr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input int first_pc, input int n);
    chk("stream_len", got_q.size(), n);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("stream_pc", {27'd0, got_q[i].pc}, first_pc + i);
      chk("stream_data", got_q[i].dat, exp_mem[(first_pc + i) % 32]);
    end
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.inst_ready = 1;
    bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;

    // reset state
    #12;
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_imem_mode", bus.imem_mode, 1);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_halted", bus.halted, 0);
    rst = 1'b0;
    #1;
    chk("idle_load_ready", bus.load_ready, 1);

    // start latency and first words
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    @(negedge clk);
    chk("issue0_addr", bus.imem_addr, 0);
    chk("issue0_mode", bus.imem_mode, 1);
    @(negedge clk);
    chk("lat_not_yet", bus.inst_valid, 0);
    @(negedge clk);
    chk("first_valid", bus.inst_valid, 1);
    chk("first_pc", bus.inst_pc, 0);
    chk("first_data", bus.inst_data, 32'h0022_0020);
    @(negedge clk);
    chk("second_pc", bus.inst_pc, 1);
    chk("second_data", bus.inst_data, 32'h0041_0022);
    repeat (3) tick();

    // decode stall for 3 cycles
    bus.inst_ready = 0;
    @(negedge clk);
    chk("stall_valid", bus.inst_valid, 1);
    chk("stall_pc", bus.inst_pc, 4);
    chk("stall_data", bus.inst_data, img(4));
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      chk("hold_pc", bus.inst_pc, 4);
      chk("hold_data", bus.inst_data, img(4));
      chk("hold_valid", bus.inst_valid, 1);
    end
    tick(); bus.inst_ready = 1;
    repeat (4) tick();
    check_stream(0, 8);

    // redirect with a full buffer
    bus.inst_ready = 0;
    tick();
    tick(); bus.redirect_valid = 1; bus.redirect_pc = 5'd20;
    tick(); bus.redirect_valid = 0; bus.inst_ready = 1;
    @(negedge clk);
    chk("flush_valid", bus.inst_valid, 0);
    chk("redirect_issue", bus.imem_addr, 20);

    // run to end of memory
    repeat (8) tick();
    check_stream(20, 5);
    chk("halted", bus.halted, 1);
    chk("halt_drained", bus.inst_valid, 0);
    chk("halt_load_ready", bus.load_ready, 1);
    chk("no_addr_25", bad_addr, 0);

    rst = 1; #1;
    chk("rst2_halted", bus.halted, 0);
    chk("rst2_valid", bus.inst_valid, 0);
    #1 rst = 0;

    // program load in IDLE, second load together with start
    bus.load_valid = 1; bus.load_addr = 5'd3; bus.load_data = 32'hDEAD_BEEF;
    #1;
    chk("load_mode", bus.imem_mode, 0);
    chk("load_addr", bus.imem_addr, 3);
    chk("load_wdata", bus.imem_wdata, 32'hDEAD_BEEF);
    chk("load_ready", bus.load_ready, 1);
    wr_base = wr_cycles;
    exp_mem[3] = 32'hDEAD_BEEF;
    tick(); bus.load_addr = 5'd5; bus.load_data = 32'h55AA_55AA; bus.start = 1;
    exp_mem[5] = 32'h55AA_55AA;
    #1;
    chk("load2_mode", bus.imem_mode, 0);
    tick(); bus.load_valid = 0; bus.start = 0;
    #1;
    chk("fetch_mode", bus.imem_mode, 1);
    chk("fetch_load_ready", bus.load_ready, 0);
    tick(); bus.load_valid = 1; bus.load_addr = 5'd7; bus.load_data = 32'h1234_5678;
    #1;
    chk("fetch_load_ignored_rdy", bus.load_ready, 0);
    chk("fetch_load_ignored_mode", bus.imem_mode, 1);
    tick();
    tick(); bus.load_valid = 0;
    repeat (5) tick();
    check_stream(0, 6);
    chk("write_cycles", wr_cycles - wr_base, 2);

    // asynchronous reset mid-stream
    #2 rst = 1;
    #1;
    chk("arst_valid", bus.inst_valid, 0);
    chk("arst_mode", bus.imem_mode, 1);
    chk("arst_addr", bus.imem_addr, 0);
    #1 rst = 0;
    got_q.delete();
    bus.redirect_valid = 1; bus.redirect_pc = 5'd4;
    tick(); bus.redirect_valid = 0;
    repeat (2) tick();
    chk("idle_after_rst_valid", bus.inst_valid, 0);
    chk("idle_after_rst_ready", bus.load_ready, 1);
    chk("idle_redirect_ignored", got_q.size(), 0);
    chk("idle_addr", bus.imem_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
